// File: rtl/div_sched.sv
// div_sched: round-robin scheduler sharing one fixed-point signed divider
// among N_REQ requesters. Accepted pairs travel through a DIV_LAT-stage pipeline
// into an output FIFO tagged with the requester index. Issue is credit-gated,
// so the FIFO can never overflow, even under output backpressure.
// Optional build macro: DIV_SCHED_DZ_EN (saturate on divide-by-zero, flag o_dz).
//
// Handshakes: a requester transfer happens on a rising edge where
// req_vld[i] & req_rdy[i]; a result transfer happens where o_vld & o_rdy.
// req_rdy is a combinational function of req_vld, so req_vld must never
// depend on req_rdy. o_c/o_id/o_dz are held while o_vld & !o_rdy.
module div_sched #(
    parameter int N_REQ      = 4,
    parameter int W          = 32,
    parameter int FRAC       = 3,
    parameter int DIV_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic [N_REQ-1:0]         req_vld,
    input  logic [N_REQ*W-1:0]       req_a,
    input  logic [N_REQ*W-1:0]       req_b,
    output logic [N_REQ-1:0]         req_rdy,
    output logic                     o_vld,
    input  logic                     o_rdy,
    output logic [W-1:0]             o_c,
    output logic [$clog2(N_REQ)-1:0] o_id,
    output logic                     o_dz
);

    localparam int IDW = $clog2(N_REQ);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH) + 2;
    localparam int L   = DIV_LAT - 1;

    logic [IDW-1:0] rr_ptr;
    logic           started;
    logic [CW-1:0]  fifo_count;
    logic [CW-1:0]  inflight;
    logic           issue_ok;
    logic           found;
    logic [IDW:0]   sum;
    logic [IDW-1:0] grant_id;
    logic           accept;

    // pipeline stage registers
    logic [DIV_LAT-1:0] pv;
    logic [W-1:0]       pa  [DIV_LAT];
    logic [W-1:0]       pb  [DIV_LAT];
    logic [IDW-1:0]     pid [DIV_LAT];

    // divider datapath at the last stage
    logic signed [2*W-1:0] num;
    logic signed [2*W-1:0] den;
    logic [W-1:0]          quo;
    logic [W-1:0]          res_c;
    logic                  res_dz;

    // output FIFO
    logic [W-1:0]   f_c  [FIFO_DEPTH];
    logic [IDW-1:0] f_id [FIFO_DEPTH];
    logic           f_dz [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           fifo_wr;
    logic           pop;

    // A slot is committed from acceptance until pop, so count+inflight must stay
    // below the depth; 'started' keeps req_rdy low until the first edge after reset.
    assign issue_ok = started && ((fifo_count + inflight) < CW'(FIFO_DEPTH));

    // Round-robin search starting just after the last granted index.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        sum      = '0;
        req_rdy  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(N_REQ)) sum = sum - (IDW+1)'(N_REQ);
            if (!found && req_vld[sum[IDW-1:0]]) begin
                found    = 1'b1;
                grant_id = sum[IDW-1:0];
            end
        end
        if (issue_ok && found) req_rdy[grant_id] = 1'b1;
    end

    assign accept = |req_rdy;

    // Round-robin pointer and post-reset start flag.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rr_ptr  <= IDW'(N_REQ - 1);
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            if (accept) rr_ptr <= grant_id;
        end
    end

    // Operand pipeline: stage 0 captures the accepted pair, later stages shift.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pv <= '0;
            for (int i = 0; i < DIV_LAT; i++) begin
                pa[i]  <= '0;
                pb[i]  <= '0;
                pid[i] <= '0;
            end
        end else begin
            pv[0]  <= accept;
            pa[0]  <= req_a[grant_id*W +: W];
            pb[0]  <= req_b[grant_id*W +: W];
            pid[0] <= grant_id;
            for (int i = 1; i < DIV_LAT; i++) begin
                pv[i]  <= pv[i-1];
                pa[i]  <= pa[i-1];
                pb[i]  <= pb[i-1];
                pid[i] <= pid[i-1];
            end
        end
    end

    // (a <<< FRAC) / b at 2W bits; signed division truncates toward zero.
    assign num = $signed({{W{pa[L][W-1]}}, pa[L]}) <<< FRAC;
    assign den = $signed({{W{pb[L][W-1]}}, pb[L]});
    assign quo = W'(num / den);

`ifdef DIV_SCHED_DZ_EN
    // Zero divisor bypasses the divider with a sign-dependent saturated value.
    always_comb begin
        res_c  = quo;
        res_dz = 1'b0;
        if (pb[L] == '0) begin
            res_dz = 1'b1;
            res_c  = pa[L][W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    assign res_c  = quo;
    assign res_dz = 1'b0;
`endif

    assign fifo_wr = pv[L];
    assign pop     = o_vld & o_rdy;

    // FIFO storage and pointers; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                f_c[i]  <= '0;
                f_id[i] <= '0;
                f_dz[i] <= 1'b0;
            end
        end else begin
            if (fifo_wr) begin
                f_c[wr_ptr]  <= res_c;
                f_id[wr_ptr] <= pid[L];
                f_dz[wr_ptr] <= res_dz;
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Occupancy counters for the FIFO and the pipeline.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            fifo_count <= '0;
            inflight   <= '0;
        end else begin
            case ({fifo_wr, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            case ({accept, fifo_wr})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    assign o_vld = (fifo_count != '0);
    assign o_c   = f_c[rd_ptr];
    assign o_id  = f_id[rd_ptr];
    assign o_dz  = f_dz[rd_ptr];

    // A write into a full FIFO without a simultaneous pop must never happen.
    a_no_overflow: assert property (@(posedge clk) disable iff (arst)
        !(fifo_wr && !pop && fifo_count == CW'(FIFO_DEPTH)));

endmodule
